// File: rtl/ltc2600_pkg.sv
// Shared definitions for the LTC2600 serial link: command codes, the
// all-channels address, legal frame lengths and the responder FSM states.
// The DAC writer imports this same package so both ends agree on encodings.
package ltc2600_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE_IN      = 4'h0,
    CMD_UPD           = 4'h1,
    CMD_WRITE_UPD_ALL = 4'h2,
    CMD_WRITE_UPD     = 4'h3,
    CMD_PWR_DN        = 4'h4,
    CMD_NOP           = 4'hF
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE
  } state_e;

  localparam logic [3:0] ADDR_ALL         = 4'hF;
  localparam int         FRAME_BITS_SHORT = 24;
  localparam int         FRAME_BITS_LONG  = 32;
  localparam int         SHREG_BITS       = 32;
  localparam int         CNT_BITS         = 6;

  // A frame is legal only when exactly 24 or 32 bits were clocked in.
  function automatic logic frame_len_ok(input logic [CNT_BITS-1:0] cnt);
    return (cnt == CNT_BITS'(FRAME_BITS_SHORT)) ||
           (cnt == CNT_BITS'(FRAME_BITS_LONG));
  endfunction

endpackage

// File: rtl/ltc2600_spi_responder_if.sv
// SPI pin bundle between a DAC writer (master) and the LTC2600 responder
// (slave). The sdo echo pin exists only when LTC2600_SDO_ECHO_EN is defined.
interface ltc2600_spi_responder_if;

  logic sck;
  logic sdi;
  logic csb;
  logic clrb;

`ifdef LTC2600_SDO_ECHO_EN
  logic sdo;

  modport master (output sck, output sdi, output csb, output clrb, input  sdo);
  modport slave  (input  sck, input  sdi, input  csb, input  clrb, output sdo);
`else
  modport master (output sck, output sdi, output csb, output clrb);
  modport slave  (input  sck, input  sdi, input  csb, input  clrb);
`endif

endinterface

// File: rtl/spi_input_sync.sv
// Brings the asynchronous SPI pins into the clk domain through a chain of
// SYNC_STAGES flops and derives one-cycle edge strobes from the synced levels.
// Reset levels match an idle bus (csb/clrb high, sck/sdi low) so releasing
// reset on an idle bus never fabricates a csb or sck edge.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sck,
  input  logic i_sdi,
  input  logic i_csb,
  input  logic i_clrb,
  output logic o_sck,
  output logic o_sdi,
  output logic o_csb,
  output logic o_clrb,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_csb_rise,
  output logic o_csb_fall
);

  // Bit order in every vector below: {clrb, csb, sdi, sck}
  localparam logic [3:0] RST_LEVEL = 4'b1100;

  logic [3:0] w_pin;
  logic [3:0] w_synced;
  logic [3:0] r_sync [SYNC_STAGES];
  logic [3:0] r_prev;

  assign w_pin    = {i_clrb, i_csb, i_sdi, i_sck};
  assign w_synced = r_sync[SYNC_STAGES-1];

  // Synchronizer chain plus one extra flop holding the previous synced level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= RST_LEVEL;
      r_prev <= RST_LEVEL;
    end else begin
      r_sync[0] <= w_pin;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_synced;
    end
  end

  assign o_sck  = w_synced[0];
  assign o_sdi  = w_synced[1];
  assign o_csb  = w_synced[2];
  assign o_clrb = w_synced[3];

  assign o_sck_rise =  w_synced[0] & ~r_prev[0];
  assign o_sck_fall = ~w_synced[0] &  r_prev[0];
  assign o_csb_rise =  w_synced[2] & ~r_prev[2];
  assign o_csb_fall = ~w_synced[2] &  r_prev[2];

endmodule

// File: rtl/ltc2600_spi_responder.sv
// LTC2600 octal DAC serial-input responder. Oversamples the SPI pins in clk,
// shifts in 24/32-bit frames, decodes {cmd, addr, data} and maintains the
// per-channel input register, DAC register and power-up state.
// Optional feature macro: LTC2600_SDO_ECHO_EN adds the daisy-chain sdo echo.
module ltc2600_spi_responder
  import ltc2600_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  ltc2600_spi_responder_if.slave       spi,
  output logic [NUM_CH*DATA_WIDTH-1:0] dac_code,
  output logic [NUM_CH-1:0]            dac_on,
  output logic                         frame_valid,
  output logic [3:0]                   frame_cmd,
  output logic [3:0]                   frame_addr,
  output logic [DATA_WIDTH-1:0]        frame_data,
  output logic                         frame_error,
  output logic                         addr_error
);

  // Synced pin levels and edge strobes
  logic w_sck_s, w_sdi_s, w_csb_s, w_clrb_s;
  logic w_sck_rise, w_sck_fall, w_csb_rise, w_csb_fall;

  spi_input_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .i_sck      (spi.sck),
    .i_sdi      (spi.sdi),
    .i_csb      (spi.csb),
    .i_clrb     (spi.clrb),
    .o_sck      (w_sck_s),
    .o_sdi      (w_sdi_s),
    .o_csb      (w_csb_s),
    .o_clrb     (w_clrb_s),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_csb_rise (w_csb_rise),
    .o_csb_fall (w_csb_fall)
  );

  state_e                  r_state;
  state_e                  w_state_next;
  logic [SHREG_BITS-1:0]   r_shreg;
  logic [CNT_BITS-1:0]     r_cnt;

  // A bit is taken only on an sck rise seen while the frame is selected
  logic w_bit_edge;
  assign w_bit_edge = w_sck_rise & ~w_csb_s;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state: an empty select (no bits) returns to IDLE silently
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_csb_fall) w_state_next = ST_SHIFT;
      ST_SHIFT:  if (w_csb_rise) w_state_next = (r_cnt == '0) ? ST_IDLE : ST_DECODE;
      ST_DECODE: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Shift register and saturating bit counter; the count restarts in IDLE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == ST_SHIFT) && w_bit_edge) begin
      r_shreg <= {r_shreg[SHREG_BITS-2:0], w_sdi_s};
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Decode of the last DATA_WIDTH+8 bits clocked in
  logic                  w_decode;
  logic                  w_len_ok;
  logic                  w_addr_ok;
  logic                  w_wr_en;
  logic [3:0]            w_f_cmd;
  logic [3:0]            w_f_addr;
  logic [DATA_WIDTH-1:0] w_f_data;

  assign w_decode  = (r_state == ST_DECODE);
  assign w_len_ok  = frame_len_ok(r_cnt);
  assign w_f_cmd   = r_shreg[DATA_WIDTH+7 -: 4];
  assign w_f_addr  = r_shreg[DATA_WIDTH+3 -: 4];
  assign w_f_data  = r_shreg[DATA_WIDTH-1:0];
  assign w_addr_ok = (w_f_addr == ADDR_ALL) || (int'(w_f_addr) < NUM_CH);
  // Writes need a legal frame on a legal address with clear released
  assign w_wr_en   = w_decode & w_len_ok & w_addr_ok & w_clrb_s;

  // Status pulses and the held copy of the last legal frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      addr_error  <= 1'b0;
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
    end else begin
      frame_valid <= w_decode &  w_len_ok;
      frame_error <= w_decode & ~w_len_ok;
      addr_error  <= w_decode &  w_len_ok & ~w_addr_ok;
      if (w_decode && w_len_ok) begin
        frame_cmd  <= w_f_cmd;
        frame_addr <= w_f_addr;
        frame_data <= w_f_data;
      end
    end
  end

  // Per-channel input/DAC registers and power state
  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] r_in;
    logic [DATA_WIDTH-1:0] r_dac;
    logic                  r_on;
    logic                  w_sel;

    assign w_sel = (w_f_addr == ADDR_ALL) || (w_f_addr == 4'(gi));

    // Clear wins over any write; power state survives a clear.
    // For write-and-update-all, unselected channels copy their own input.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_in  <= '0;
        r_dac <= '0;
        r_on  <= 1'b0;
      end else if (!w_clrb_s) begin
        r_in  <= '0;
        r_dac <= '0;
      end else if (w_wr_en) begin
        case (w_f_cmd)
          CMD_WRITE_IN: begin
            if (w_sel) r_in <= w_f_data;
          end
          CMD_UPD: begin
            if (w_sel) begin
              r_dac <= r_in;
              r_on  <= 1'b1;
            end
          end
          CMD_WRITE_UPD_ALL: begin
            r_on <= 1'b1;
            if (w_sel) begin
              r_in  <= w_f_data;
              r_dac <= w_f_data;
            end else begin
              r_dac <= r_in;
            end
          end
          CMD_WRITE_UPD: begin
            if (w_sel) begin
              r_in  <= w_f_data;
              r_dac <= w_f_data;
              r_on  <= 1'b1;
            end
          end
          CMD_PWR_DN: begin
            if (w_sel) r_on <= 1'b0;
          end
          CMD_NOP: ;
          default: ;
        endcase
      end
    end

    // A powered-down channel presents code zero
    assign dac_code[gi*DATA_WIDTH +: DATA_WIDTH] = r_on ? r_dac : '0;
    assign dac_on[gi] = r_on;
  end

`ifdef LTC2600_SDO_ECHO_EN
  logic r_sdo;

  // Daisy-chain echo: the bit leaving the 32-bit shifter, launched on sck fall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           r_sdo <= 1'b0;
    else if (w_csb_s)    r_sdo <= 1'b0;
    else if (w_sck_fall) r_sdo <= r_shreg[SHREG_BITS-1];
  end

  assign spi.sdo = r_sdo;

  logic w_unused_ok;
  assign w_unused_ok = w_sck_s;
`else
  // The shifter MSB and sck-fall strobe only feed the optional echo
  logic w_unused_ok;
  assign w_unused_ok = ^{r_shreg[SHREG_BITS-1], w_sck_fall, w_sck_s};
`endif

endmodule

// File: tb/tb_ltc2600_spi_responder.sv
// Self-checking bench for ltc2600_spi_responder: directed vector table,
// hand sequences for clear/reset/empty-select, then random frames checked
// against a channel-array reference model.
module tb_ltc2600_spi_responder;

  localparam int DW   = 16;
  localparam int NCH  = 8;
  localparam int SS   = 2;
  localparam int HALF = 4;   // clk cycles per sck half period

  logic                clk  = 1'b0;
  logic                rstn = 1'b0;
  logic [NCH*DW-1:0]   dac_code;
  logic [NCH-1:0]      dac_on;
  logic                frame_valid, frame_error, addr_error;
  logic [3:0]          frame_cmd, frame_addr;
  logic [DW-1:0]       frame_data;

  ltc2600_spi_responder_if spi_if ();

  ltc2600_spi_responder #(
    .DATA_WIDTH  (DW),
    .NUM_CH      (NCH),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .spi         (spi_if),
    .dac_code    (dac_code),
    .dac_on      (dac_on),
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_error (frame_error),
    .addr_error  (addr_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Running counts of cycles each pulse output was high
  int cnt_v = 0, cnt_e = 0, cnt_a = 0;
  always @(negedge clk) begin
    if (frame_valid) cnt_v++;
    if (frame_error) cnt_e++;
    if (addr_error)  cnt_a++;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_in  [NCH];
  logic [DW-1:0] m_dac [NCH];
  logic          m_on  [NCH];
  logic [3:0]    m_cmd, m_addr;
  logic [DW-1:0] m_data;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_in[c] = '0; m_dac[c] = '0; m_on[c] = 1'b0;
    end
    m_cmd = '0; m_addr = '0; m_data = '0;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_in[c] = '0; m_dac[c] = '0;
    end
  endfunction

  function automatic void model_frame(input logic [23:0] f, input int nbits, input bit clr_low,
                                      output int ev, output int ee, output int ea);
    logic [3:0]    cmd;
    logic [3:0]    addr;
    logic [DW-1:0] data;
    bit            legal;
    cmd   = f[23:20];
    addr  = f[19:16];
    data  = f[15:0];
    legal = (addr == 4'hF) || (int'(addr) < NCH);
    ev = (nbits == 24 || nbits == 32) ? 1 : 0;
    ee = (ev == 0) ? 1 : 0;
    ea = (ev == 1 && !legal) ? 1 : 0;
    if (ev == 0) return;
    m_cmd = cmd; m_addr = addr; m_data = data;
    if (!legal || clr_low) return;
    for (int c = 0; c < NCH; c++) begin
      if (addr != 4'hF && int'(addr) != c) continue;
      case (cmd)
        4'h0: m_in[c] = data;
        4'h1: begin m_dac[c] = m_in[c]; m_on[c] = 1'b1; end
        4'h2: m_in[c] = data;
        4'h3: begin m_in[c] = data; m_dac[c] = data; m_on[c] = 1'b1; end
        4'h4: m_on[c] = 1'b0;
        default: ;
      endcase
    end
    if (cmd == 4'h2) begin
      for (int c = 0; c < NCH; c++) begin
        m_dac[c] = m_in[c];
        m_on[c]  = 1'b1;
      end
    end
  endfunction

  function automatic logic [127:0] model_code();
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c*DW +: DW] = m_on[c] ? m_dac[c] : '0;
    return v;
  endfunction

  function automatic logic [127:0] model_on();
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c] = m_on[c];
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] word, input int nbits);
    spi_if.csb = 1'b0;
    wait_clk(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_if.sdi = word[i];
      wait_clk(HALF);
      spi_if.sck = 1'b1;
      wait_clk(HALF);
      spi_if.sck = 1'b0;
    end
    wait_clk(HALF);
    spi_if.csb = 1'b1;
    wait_clk(12);
  endtask

  task automatic run_frame(input string nm, input logic [63:0] word, input int nbits,
                           output int dv, output int de, output int da);
    int v0, e0, a0, ev, ee, ea;
    bit clr_low;
    v0 = cnt_v; e0 = cnt_e; a0 = cnt_a;
    clr_low = !spi_if.clrb;
    send_frame(word, nbits);
    model_frame(word[23:0], nbits, clr_low, ev, ee, ea);
    dv = cnt_v - v0; de = cnt_e - e0; da = cnt_a - a0;
    $display("%s: frame %h bits %0d valid %0d err %0d aerr %0d on %h", nm, word[23:0], nbits, dv, de, da, dac_on);
    chk({nm, ".valid"}, 128'(dv), 128'(ev));
    chk({nm, ".ferr"},  128'(de), 128'(ee));
    chk({nm, ".aerr"},  128'(da), 128'(ea));
    chk({nm, ".code"},  128'(dac_code), model_code());
    chk({nm, ".on"},    128'(dac_on), model_on());
    if (ev != 0) begin
      chk({nm, ".fcmd"},  128'(frame_cmd),  128'(m_cmd));
      chk({nm, ".faddr"}, 128'(frame_addr), 128'(m_addr));
      chk({nm, ".fdata"}, 128'(frame_data), 128'(m_data));
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".code"},  128'(dac_code), 128'(0));
    chk({nm, ".on"},    128'(dac_on), 128'(0));
    chk({nm, ".valid"}, 128'(frame_valid), 128'(0));
    chk({nm, ".ferr"},  128'(frame_error), 128'(0));
    chk({nm, ".aerr"},  128'(addr_error), 128'(0));
    chk({nm, ".fcmd"},  128'(frame_cmd), 128'(0));
    chk({nm, ".faddr"}, 128'(frame_addr), 128'(0));
    chk({nm, ".fdata"}, 128'(frame_data), 128'(0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [63:0] word;
    int          nbits;
    int          ch;
    logic [15:0] exp_code;
    logic [7:0]  exp_on;
    int          exp_v;
    int          exp_e;
    int          exp_a;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv, de, da;
    logic [3:0]  cmd, addr;
    logic [15:0] data;
    logic [63:0] word;
    int          nbits;
    int          v0, e0, a0;

    tbl[0] = '{{40'h0, 4'h3, 4'h5, 16'hFFFF}, 24, 5, 16'hFFFF, 8'h20, 1, 0, 0};
    tbl[1] = '{{40'h0, 4'h1, 4'h8, 16'hAAAA}, 24, 5, 16'hFFFF, 8'h20, 1, 0, 1};
    tbl[2] = '{{32'h0, 8'hA5, 4'h0, 4'hF, 16'h1234}, 32, 5, 16'hFFFF, 8'h20, 1, 0, 0};
    tbl[3] = '{{40'h0, 4'h1, 4'hF, 16'h0000}, 24, 3, 16'h1234, 8'hFF, 1, 0, 0};
    tbl[4] = '{{40'h0, 4'h3, 4'h2, 16'h5555}, 13, 3, 16'h1234, 8'hFF, 0, 1, 0};
    tbl[5] = '{{40'h0, 4'h3, 4'h2, 16'h00FF}, 24, 2, 16'h00FF, 8'hFF, 1, 0, 0};

    spi_if.sck  = 1'b0;
    spi_if.sdi  = 1'b0;
    spi_if.csb  = 1'b1;
    spi_if.clrb = 1'b1;
    rstn        = 1'b0;
    model_reset();
    wait_clk(5);
    chk_reset_state("reset");
    rstn = 1'b1;
    wait_clk(5);

    // Directed table
    for (int r = 0; r < 6; r++) begin
      run_frame($sformatf("vec%0d", r), tbl[r].word, tbl[r].nbits, dv, de, da);
      chk($sformatf("vec%0d.ch", r), 128'(dac_code[tbl[r].ch*DW +: DW]), 128'(tbl[r].exp_code));
      chk($sformatf("vec%0d.on_t", r), 128'(dac_on), 128'(tbl[r].exp_on));
      chk($sformatf("vec%0d.v_t", r), 128'(dv), 128'(tbl[r].exp_v));
      chk($sformatf("vec%0d.e_t", r), 128'(de), 128'(tbl[r].exp_e));
      chk($sformatf("vec%0d.a_t", r), 128'(da), 128'(tbl[r].exp_a));
    end

    // Empty select: no bits, no pulses
    v0 = cnt_v; e0 = cnt_e; a0 = cnt_a;
    spi_if.csb = 1'b0;
    wait_clk(20);
    spi_if.csb = 1'b1;
    wait_clk(12);
    $display("empty: pulses valid %0d err %0d aerr %0d", cnt_v - v0, cnt_e - e0, cnt_a - a0);
    chk("empty.pulses", 128'((cnt_v - v0) + (cnt_e - e0) + (cnt_a - a0)), 128'(0));

    // Clear held low: registers zeroed, writes during clear discarded
    spi_if.clrb = 1'b0;
    wait_clk(10);
    model_clear();
    $display("clrb low: code %h on %h", dac_code, dac_on);
    chk("clrb.ch2", 128'(dac_code[2*DW +: DW]), 128'(0));
    chk("clrb.code", 128'(dac_code), model_code());
    chk("clrb.on", 128'(dac_on), 128'(8'hFF));
    run_frame("clrb_frame", {40'h0, 4'h3, 4'h2, 16'h0042}, 24, dv, de, da);
    chk("clrb_frame.ch2", 128'(dac_code[2*DW +: DW]), 128'(0));
    spi_if.clrb = 1'b1;
    wait_clk(10);
    $display("clrb released: code %h on %h", dac_code, dac_on);
    chk("clrb_rel.ch2", 128'(dac_code[2*DW +: DW]), 128'(0));
    chk("clrb_rel.code", 128'(dac_code), model_code());

    // Async reset in the middle of a frame
    word = {40'h0, 4'h3, 4'h1, 16'h7777};
    spi_if.csb = 1'b0;
    wait_clk(HALF);
    for (int i = 23; i > 13; i--) begin
      spi_if.sdi = word[i];
      wait_clk(HALF);
      spi_if.sck = 1'b1;
      wait_clk(HALF);
      spi_if.sck = 1'b0;
    end
    rstn = 1'b0;
    wait_clk(2);
    model_reset();
    chk_reset_state("midrst_in");
    spi_if.csb = 1'b1;
    spi_if.sck = 1'b0;
    wait_clk(4);
    rstn = 1'b1;
    wait_clk(6);
    $display("mid-frame reset released: code %h on %h", dac_code, dac_on);
    chk_reset_state("midrst_out");
    run_frame("post_rst", {40'h0, 4'h3, 4'h0, 16'hBEEF}, 24, dv, de, da);
    chk("post_rst.ch0", 128'(dac_code[DW-1:0]), 128'(16'hBEEF));
    chk("post_rst.on_t", 128'(dac_on), 128'(8'h01));

    // Random frames against the model
    for (int n = 0; n < 40; n++) begin
      int pick;
      pick = $urandom_range(0, 7);
      if (pick <= 4)      cmd = 4'(pick);
      else if (pick == 5) cmd = 4'hF;
      else                cmd = 4'($urandom_range(5, 14));
      addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      data = 16'($urandom);
      pick = $urandom_range(0, 9);
      if (pick <= 4)      nbits = 24;
      else if (pick <= 7) nbits = 32;
      else if (pick == 8) nbits = $urandom_range(1, 23);
      else                nbits = $urandom_range(25, 40);
      if (nbits == 32) nbits = 33;
      if (pick >= 5 && pick <= 7) nbits = 32;
      word = {32'($urandom), 8'($urandom), cmd, addr, data};
      run_frame($sformatf("rnd%0d", n), word, nbits, dv, de, da);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
